// File: rtl/cache_pkg.sv
// cache_pkg: shared encodings for the L1 cache controller.
// MESI states, snoop request/response codes, CPU response codes,
// request-sequencer state encodings and request-status bit positions.
package cache_pkg;

    // MESI block states
    localparam logic [2:0] INVALID   = 3'd0,
                           SHARED    = 3'd1,
                           EXCLUSIVE = 3'd2,
                           MODIFIED  = 3'd3;

    // Downstream snoop request codes
    localparam logic [2:0] SDREQ_NONE = 3'd0,
                           SDREQ_RD   = 3'd1,
                           SDREQ_RFO  = 3'd2,
                           SDREQ_INV  = 3'd3,
                           SDREQ_WB   = 3'd4;

    // Upstream snoop response codes
    localparam logic [2:0] SURSP_NONE  = 3'd0,
                           SURSP_FETCH = 3'd1,
                           SURSP_SNOOP = 3'd2,
                           SURSP_OKAY  = 3'd3;

    // CPU response codes
    localparam logic [1:0] CURSP_NONE  = 2'd0,
                           CURSP_OKAY  = 2'd1;

    // Bit positions inside the one-hot req_status vector
    localparam int READ_HIT   = 0;
    localparam int WRITE_HIT  = 1;
    localparam int READ_MISS  = 2;
    localparam int WRITE_MISS = 3;

    // Request sequencer states; REQ_VICTIM_WB is only reachable with the
    // victim writeback feature compiled in.
    typedef enum logic [2:0] {
        REQ_IDLE       = 3'd0,
        REQ_LOOKUP     = 3'd1,
        REQ_SEND_SDREQ = 3'd2,
        REQ_WAIT_SURSP = 3'd3,
        REQ_RSP_CURSP  = 3'd4,
        REQ_VICTIM_WB  = 3'd5
    } req_state_t;

    // One-hot classification of a request from its op and the lookup hit.
    function automatic logic [3:0] classify(input logic is_write, input logic hit);
        logic [3:0] st;
        st = '0;
        case ({is_write, hit})
            2'b01:   st[READ_HIT]   = 1'b1;
            2'b11:   st[WRITE_HIT]  = 1'b1;
            2'b00:   st[READ_MISS]  = 1'b1;
            default: st[WRITE_MISS] = 1'b1;
        endcase
        return st;
    endfunction

endpackage

// File: rtl/l1_req_seq.sv
// l1_req_seq: sequential request sequencer for one L1 cache controller.
// Accepts one CPU request at a time, classifies it after a one-cycle array
// lookup, drives the snoop request chosen by the external decision logic,
// collects the snoop response, answers the CPU and commits the next MESI
// state into the array.
// Optional feature: define L1_VICTIM_WB_EN to write back a MODIFIED victim
// (REQ_VICTIM_WB) before the fill request of a miss.
module l1_req_seq
    import cache_pkg::*;
#(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 64,
    parameter int INDEX_WIDTH = 6
) (
    input  logic                              clk,
    input  logic                              rst_n,
    // CPU request
    input  logic                              cdreq_valid,
    output logic                              cdreq_ready,
    input  logic                              cdreq_op,
    input  logic [ADDR_WIDTH-1:0]             cdreq_addr,
    input  logic [DATA_WIDTH-1:0]             cdreq_data,
    // CPU response
    output logic                              cursp_valid,
    input  logic                              cursp_ready,
    output logic [1:0]                        cursp_rsp,
    output logic [DATA_WIDTH-1:0]             cursp_data,
    // downstream snoop request
    output logic                              sdreq_valid,
    input  logic                              sdreq_ready,
    output logic [2:0]                        sdreq_op,
    output logic [ADDR_WIDTH-1:0]             sdreq_addr,
    output logic [DATA_WIDTH-1:0]             sdreq_data,
    // upstream snoop response
    input  logic                              sursp_valid,
    input  logic [2:0]                        sursp_rsp,
    input  logic [DATA_WIDTH-1:0]             sursp_data,
    // cache array
    output logic [INDEX_WIDTH-1:0]            arr_rd_idx,
    input  logic                              arr_rd_hit,
    input  logic [2:0]                        arr_rd_st,
    input  logic [DATA_WIDTH-1:0]             arr_rd_data,
    input  logic [ADDR_WIDTH-INDEX_WIDTH-1:0] arr_rd_tag,
    output logic                              arr_wr_en,
    output logic [INDEX_WIDTH-1:0]            arr_wr_idx,
    output logic [2:0]                        arr_wr_st,
    output logic [DATA_WIDTH-1:0]             arr_wr_data,
    // decision logic
    output logic [3:0]                        req_status,
    output logic [2:0]                        req_curSt,
    output logic [2:0]                        blk_curSt,
    output logic [2:0]                        sursp_lat,
    input  logic [2:0]                        blk_nxtSt,
    input  logic [2:0]                        init_sdreq,
    input  logic [1:0]                        dec_cursp_rsp
);

    req_state_t              r_state;
    req_state_t              w_next;

    logic                    r_op;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [DATA_WIDTH-1:0]   r_wdata;
    logic [DATA_WIDTH-1:0]   r_arr_data;
    logic [DATA_WIDTH-1:0]   r_fill_data;
    logic [3:0]              r_req_status;
    logic [2:0]              r_blk_st;
    logic [2:0]              r_sdreq_op;
    logic [2:0]              r_sursp_lat;
    logic [1:0]              r_cursp_rsp;

    logic                    w_hit;
    logic [3:0]              w_status;
    logic                    w_in_lookup;
    logic                    w_accept;
    logic                    w_sursp_take;
    logic                    w_is_miss;
    logic                    w_enter_rsp;

`ifdef L1_VICTIM_WB_EN
    logic [ADDR_WIDTH-INDEX_WIDTH-1:0] r_victim_tag;
    logic                              w_victim;
    // a tag mismatch over a dirty line must be written back first
    assign w_victim = !arr_rd_hit && (arr_rd_st == MODIFIED);
`else
    logic w_unused_tag;
    assign w_unused_tag = ^arr_rd_tag;
`endif

    assign w_hit        = arr_rd_hit && (arr_rd_st != INVALID);
    assign w_status     = classify(r_op, w_hit);
    assign w_in_lookup  = (r_state == REQ_LOOKUP);
    assign w_accept     = (r_state == REQ_IDLE) && cdreq_valid;
    assign w_sursp_take = (r_state == REQ_WAIT_SURSP) && sursp_valid;
    assign w_is_miss    = r_req_status[READ_MISS] | r_req_status[WRITE_MISS];
    assign w_enter_rsp  = (r_state != REQ_RSP_CURSP) && (w_next == REQ_RSP_CURSP);

    // During LOOKUP the decision logic sees the live classification so that
    // init_sdreq can be latched in the same cycle.
    assign req_status = w_in_lookup ? w_status  : r_req_status;
    assign blk_curSt  = w_in_lookup ? arr_rd_st : r_blk_st;
    assign req_curSt  = r_state;
    assign sursp_lat  = r_sursp_lat;
    assign cursp_rsp  = r_cursp_rsp;

    assign arr_rd_idx  = (r_state == REQ_IDLE) ? cdreq_addr[INDEX_WIDTH-1:0]
                                               : r_addr[INDEX_WIDTH-1:0];
    assign arr_wr_idx  = r_addr[INDEX_WIDTH-1:0];
    assign arr_wr_st   = arr_wr_en ? blk_nxtSt : 3'd0;
    assign arr_wr_data = r_op                    ? r_wdata     :
                         r_req_status[READ_MISS] ? r_fill_data : r_arr_data;
    assign cursp_data  = (r_state != REQ_RSP_CURSP) ? '0          :
                         w_is_miss                  ? r_fill_data : r_arr_data;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= REQ_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and handshake outputs
    always_comb begin
        w_next      = r_state;
        cdreq_ready = 1'b0;
        sdreq_valid = 1'b0;
        sdreq_op    = SDREQ_NONE;
        sdreq_addr  = '0;
        sdreq_data  = '0;
        cursp_valid = 1'b0;
        arr_wr_en   = 1'b0;
        case (r_state)
            REQ_IDLE: begin
                cdreq_ready = 1'b1;
                if (cdreq_valid) begin
                    w_next = REQ_LOOKUP;
                end
            end
            REQ_LOOKUP: begin
                if (w_status[READ_HIT]) begin
                    w_next = REQ_RSP_CURSP;
                end else if (w_status[WRITE_HIT]) begin
                    w_next = (arr_rd_st == SHARED) ? REQ_SEND_SDREQ : REQ_RSP_CURSP;
                end else begin
`ifdef L1_VICTIM_WB_EN
                    w_next = w_victim ? REQ_VICTIM_WB : REQ_SEND_SDREQ;
`else
                    w_next = REQ_SEND_SDREQ;
`endif
                end
            end
            REQ_SEND_SDREQ: begin
                sdreq_valid = 1'b1;
                sdreq_op    = r_sdreq_op;
                sdreq_addr  = r_addr;
                if (sdreq_ready) begin
                    w_next = REQ_WAIT_SURSP;
                end
            end
            REQ_WAIT_SURSP: begin
                if (sursp_valid) begin
                    w_next = REQ_RSP_CURSP;
                end
            end
            REQ_RSP_CURSP: begin
                cursp_valid = 1'b1;
                if (cursp_ready) begin
                    arr_wr_en = 1'b1;
                    w_next    = REQ_IDLE;
                end
            end
`ifdef L1_VICTIM_WB_EN
            REQ_VICTIM_WB: begin
                sdreq_valid = 1'b1;
                sdreq_op    = SDREQ_WB;
                sdreq_addr  = {r_victim_tag, r_addr[INDEX_WIDTH-1:0]};
                sdreq_data  = r_arr_data;
                if (sdreq_ready) begin
                    w_next = REQ_SEND_SDREQ;
                end
            end
`endif
            default: begin
                w_next = REQ_IDLE;
            end
        endcase
    end

    // Request, lookup and snoop-response capture registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op         <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_arr_data   <= '0;
            r_fill_data  <= '0;
            r_req_status <= '0;
            r_blk_st     <= INVALID;
            r_sdreq_op   <= SDREQ_NONE;
            r_sursp_lat  <= SURSP_NONE;
            r_cursp_rsp  <= CURSP_NONE;
`ifdef L1_VICTIM_WB_EN
            r_victim_tag <= '0;
`endif
        end else begin
            if (w_accept) begin
                r_op         <= cdreq_op;
                r_addr       <= cdreq_addr;
                r_wdata      <= cdreq_data;
                r_req_status <= '0;
                r_sursp_lat  <= SURSP_NONE;
            end
            if (w_in_lookup) begin
                r_req_status <= w_status;
                r_blk_st     <= arr_rd_st;
                r_arr_data   <= arr_rd_data;
                r_sdreq_op   <= init_sdreq;
`ifdef L1_VICTIM_WB_EN
                r_victim_tag <= arr_rd_tag;
`endif
            end
            if (w_sursp_take) begin
                r_sursp_lat <= sursp_rsp;
                r_fill_data <= sursp_data;
            end
            // response code is frozen for the whole time cursp_valid is high
            if (w_enter_rsp) begin
                r_cursp_rsp <= dec_cursp_rsp;
            end
        end
    end

endmodule
